ram_port_arbiter: RTL and testbench

//  Shares the single-port data RAM between two requesters: the rv32im core data port (port C)
//  and a DMA/debug loader (port D). It sits between the core and mem_RAM and serialises accesses.
//  It drives the RAM enable, address, write data and write mask, and returns read data with a valid strobe.

---
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port arbiter for a single-port data RAM (core C, DMA/loader D)
// Core has default priority; a saturating streak counter forces a D grant after MAX_STREAK core wins.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    input  logic [3:0]            c_wmask,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    output logic [DATA_WIDTH-1:0] c_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_wmask,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [3:0]            ram_wmask,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

    state_t                state_q, state_d;
    logic                  ram_en_q, ram_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]            ram_wmask_q, ram_wmask_d;
    logic                  c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
    logic                  c_rvalid_q, c_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic [3:0]            streak_q, streak_d;
    logic                  owner_d_q, owner_d_d;
    logic                  op_we_q, op_we_d;
    logic                  pick_d, pick_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wmask_q <= '0;
            c_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
            streak_q    <= '0;
            owner_d_q   <= 1'b0;
            op_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wmask_q <= ram_wmask_d;
            c_gnt_q     <= c_gnt_d;
            d_gnt_q     <= d_gnt_d;
            c_rvalid_q  <= c_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
            streak_q    <= streak_d;
            owner_d_q   <= owner_d_d;
            op_we_q     <= op_we_d;
        end
    end

    always_comb begin
        pick_d = d_req & (~c_req | (streak_q == MAX_S));
        pick_c = c_req & ~pick_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (c_req || d_req) state_d = ISSUE;
            ISSUE:   state_d = op_we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_en_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wmask_d = ram_wmask_q;
        c_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        c_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        c_rdata_d   = c_rdata_q;
        d_rdata_d   = d_rdata_q;
        streak_d    = streak_q;
        owner_d_d   = owner_d_q;
        op_we_d     = op_we_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    ram_en_d    = 1'b1;
                    ram_addr_d  = d_addr;
                    ram_wdata_d = d_wdata;
                    ram_wmask_d = d_we ? d_wmask : 4'b0;
                    d_gnt_d     = 1'b1;
                    owner_d_d   = 1'b1;
                    op_we_d     = d_we;
                    streak_d    = '0;
                end else if (pick_c) begin
                    ram_en_d    = 1'b1;
                    ram_addr_d  = c_addr;
                    ram_wdata_d = c_wdata;
                    ram_wmask_d = c_we ? c_wmask : 4'b0;
                    c_gnt_d     = 1'b1;
                    owner_d_d   = 1'b0;
                    op_we_d     = c_we;
                    // Only core wins against a waiting DMA count towards the streak
                    if (d_req) streak_d = (streak_q == MAX_S) ? MAX_S : streak_q + 4'd1;
                    else       streak_d = '0;
                end else begin
                    streak_d = '0;
                end
            end
            RESP: begin
                if (owner_d_q) begin
                    d_rdata_d  = ram_rdata;
                    d_rvalid_d = 1'b1;
                end else begin
                    c_rdata_d  = ram_rdata;
                    c_rvalid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wmask = ram_wmask_q;
    assign c_gnt     = c_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign c_rvalid  = c_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench for ram_port_arbiter with read-data scoreboard
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [3:0]  c_wmask, d_wmask;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        ram_en;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_wmask;

    int checks = 0;
    int errors = 0;
    logic [31:0] c_exp_q[$];
    logic [31:0] d_exp_q[$];
    logic [31:0] ram_mem [logic [29:0]];

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wmask(c_wmask),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_en) begin
            w = ram_mem.exists(ram_addr[31:2]) ? ram_mem[ram_addr[31:2]] : 32'h0;
            if (ram_wmask != 4'b0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
                ram_mem[ram_addr[31:2]] = w;
            end else begin
                ram_rdata <= w;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        checks++;
        if ((c_gnt & d_gnt) !== 1'b0) begin
            errors++; $error("FAIL gnt_exclusive: got %0h expected 0", c_gnt & d_gnt);
        end
        checks++;
        if ((c_rvalid & d_rvalid) !== 1'b0) begin
            errors++; $error("FAIL rvalid_exclusive: got %0h expected 0", c_rvalid & d_rvalid);
        end
        if (c_rvalid) begin
            checks++;
            if (c_exp_q.size() == 0) begin
                errors++; $error("FAIL c_rvalid_unexpected: got 1 expected 0");
            end else begin
                e = c_exp_q.pop_front();
                if (c_rdata !== e) begin
                    errors++; $error("FAIL c_rdata: got %0h expected %0h", c_rdata, e);
                end
            end
        end
        if (d_rvalid) begin
            checks++;
            if (d_exp_q.size() == 0) begin
                errors++; $error("FAIL d_rvalid_unexpected: got 1 expected 0");
            end else begin
                e = d_exp_q.pop_front();
                if (d_rdata !== e) begin
                    errors++; $error("FAIL d_rdata: got %0h expected %0h", d_rdata, e);
                end
            end
        end
    end

    task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] mask, output int lat);
        bit got = 0;
        logic [3:0] exp_mask;
        if (is_d) begin d_we = we; d_addr = addr; d_wdata = data; d_wmask = mask; d_req = 1'b1; end
        else      begin c_we = we; c_addr = addr; c_wdata = data; c_wmask = mask; c_req = 1'b1; end
        lat = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            got = is_d ? d_gnt : c_gnt;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++; $error("FAIL gnt_seen: got %0h expected 1", got);
        end
        if (got) begin
            checks++;
            if (ram_en !== 1'b1) begin
                errors++; $error("FAIL ram_en: got %0h expected 1", ram_en);
            end
            checks++;
            if (ram_addr !== addr) begin
                errors++; $error("FAIL ram_addr: got %0h expected %0h", ram_addr, addr);
            end
            exp_mask = we ? mask : 4'b0;
            checks++;
            if (ram_wmask !== exp_mask) begin
                errors++; $error("FAIL ram_wmask: got %0h expected %0h", ram_wmask, exp_mask);
            end
            if (we) begin
                checks++;
                if (ram_wdata !== data) begin
                    errors++; $error("FAIL ram_wdata: got %0h expected %0h", ram_wdata, data);
                end
            end
        end
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic do_read(input bit is_d, input logic [31:0] addr, input logic [31:0] exp);
        int lat;
        logic own_rv, oth_rv;
        if (is_d) d_exp_q.push_back(exp);
        else      c_exp_q.push_back(exp);
        do_access(is_d, 1'b0, addr, 32'h0, 4'h0, lat);
        @(posedge clk); #1;
        own_rv = is_d ? d_rvalid : c_rvalid;
        checks++;
        if (own_rv !== 1'b0) begin
            errors++; $error("FAIL rvalid_early: got %0h expected 0", own_rv);
        end
        checks++;
        if (ram_en !== 1'b0) begin
            errors++; $error("FAIL ram_en_cleared: got %0h expected 0", ram_en);
        end
        @(posedge clk); #1;
        own_rv = is_d ? d_rvalid : c_rvalid;
        oth_rv = is_d ? c_rvalid : d_rvalid;
        checks++;
        if (own_rv !== 1'b1) begin
            errors++; $error("FAIL rvalid_latency: got %0h expected 1", own_rv);
        end
        checks++;
        if (oth_rv !== 1'b0) begin
            errors++; $error("FAIL rvalid_other: got %0h expected 0", oth_rv);
        end
    endtask

    initial begin
        int lat, n, cyc;
        bit exp_d [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        reset_n = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h100; c_wdata = 32'h1111_1111; c_wmask = 4'hF;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h2222_2222; d_wmask = 4'hF;
        ram_rdata = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (ram_en !== 1'b0) begin
                errors++; $error("FAIL rst_ram_en: got %0h expected 0", ram_en);
            end
            checks++;
            if ({c_gnt, d_gnt} !== 2'b00) begin
                errors++; $error("FAIL rst_gnt: got %0h expected 0", {c_gnt, d_gnt});
            end
            checks++;
            if ({c_rvalid, d_rvalid} !== 2'b00) begin
                errors++; $error("FAIL rst_rvalid: got %0h expected 0", {c_rvalid, d_rvalid});
            end
            checks++;
            if (ram_addr !== 32'h0) begin
                errors++; $error("FAIL rst_ram_addr: got %0h expected 0", ram_addr);
            end
            checks++;
            if ((c_rdata | d_rdata) !== 32'h0) begin
                errors++; $error("FAIL rst_rdata: got %0h expected 0", c_rdata | d_rdata);
            end
        end
        reset_n = 1'b1;

        n = 0; cyc = 0;
        while (n < 10 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (c_gnt || d_gnt) begin
                checks++;
                if (d_gnt !== exp_d[n]) begin
                    errors++; $error("FAIL grant_order: got %0h expected %0h", d_gnt, exp_d[n]);
                end
                n++;
            end
        end
        checks++;
        if (n !== 10) begin
            errors++; $error("FAIL grant_count: got %0d expected 10", n);
        end
        c_req = 1'b0; d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        do_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $error("FAIL gnt_latency: got %0d expected 1", lat);
        end
        do_read(1'b0, 32'h10, 32'hDEAD_BEEF);

        do_access(1'b0, 1'b1, 32'h30, 32'h1122_3344, 4'hF, lat);
        do_access(1'b0, 1'b1, 32'h30, 32'h0000_AB00, 4'b0010, lat);
        do_read(1'b0, 32'h30, 32'h1122_AB44);

        for (int i = 0; i < 4; i++)
            do_access(1'b1, 1'b1, 32'h20 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF, lat);
        for (int i = 0; i < 4; i++)
            do_read(1'b0, 32'h20 + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
        do_read(1'b1, 32'h24, 32'hA5A5_0001);
        checks++;
        if (c_rdata !== 32'hA5A5_0003) begin
            errors++; $error("FAIL c_rdata_hold: got %0h expected a5a50003", c_rdata);
        end
        checks++;
        if (d_rdata !== 32'hA5A5_0001) begin
            errors++; $error("FAIL d_rdata_value: got %0h expected a5a50001", d_rdata);
        end

        do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (c_rvalid !== 1'b0) begin
                errors++; $error("FAIL rst_resp_no_rvalid: got %0h expected 0", c_rvalid);
            end
        end
        checks++;
        if (c_rdata !== 32'h0) begin
            errors++; $error("FAIL rst_resp_rdata: got %0h expected 0", c_rdata);
        end
        do_read(1'b0, 32'h30, 32'h1122_AB44);

        repeat (3) @(posedge clk);
        checks++;
        if ((c_exp_q.size() + d_exp_q.size()) !== 0) begin
            errors++; $error("FAIL scoreboard_empty: got %0d expected 0", c_exp_q.size() + d_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
